// File: rtl/reversible_gate_unit.sv
// reversible_gate_unit: two-stage pipelined bitwise reversible-gate engine
// (Feynman / Toffoli / Fredkin / Peres, forward or inverse) with a
// valid/ready handshake on both sides, a saturating accepted-operation
// counter and a sticky reversibility self-check.
module reversible_gate_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic             inv,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] P,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic [CNT_W-1:0] op_count,
    output logic             err
);

    localparam logic [1:0] MODE_FEYNMAN = 2'd0;
    localparam logic [1:0] MODE_TOFFOLI = 2'd1;
    localparam logic [1:0] MODE_FREDKIN = 2'd2;
    localparam logic [1:0] MODE_PERES   = 2'd3;

    // Three lanes travelling together: operands on the way in, results on the way out.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
    } trip_t;

    // Bitwise gate mapping; only Peres has a distinct inverse.
    function automatic trip_t apply_gate(input logic [1:0] m, input logic iv, input trip_t x);
        trip_t y;
        y = x;
        case (m)
            MODE_FEYNMAN: begin
                y.b = x.a ^ x.b;
            end
            MODE_TOFFOLI: begin
                y.c = (x.a & x.b) ^ x.c;
            end
            MODE_FREDKIN: begin
                y.b = (~x.a & x.b) | (x.a & x.c);
                y.c = (~x.a & x.c) | (x.a & x.b);
            end
            MODE_PERES: begin
                y.b = x.a ^ x.b;
                y.c = iv ? (x.c ^ (x.a & (x.a ^ x.b))) : ((x.a & x.b) ^ x.c);
            end
            default: begin
                y = x;
            end
        endcase
        return y;
    endfunction

    // Stage 1: captured operands and control
    logic       s1_valid;
    trip_t      s1_op;
    logic [1:0] s1_mode;
    logic       s1_inv;

    // Stage 2: results plus the operands that produced them
    logic       s2_valid;
    trip_t      s2_res;
    trip_t      s2_op;
    logic [1:0] s2_mode;
    logic       s2_inv;

    logic       chk_pend;

    logic       s1_adv_c;
    logic       accept_c;
    logic       s2_load_c;
    trip_t      s1_res_c;
    trip_t      chk_back_c;
    logic       chk_bad_c;

    // Handshake qualifiers; S2 frees up when empty or being drained.
    always_comb begin
        s1_adv_c  = ~s2_valid | out_ready;
        in_ready  = ~rst & (~s1_valid | s1_adv_c);
        accept_c  = in_valid & in_ready;
        s2_load_c = s1_valid & s1_adv_c;
    end

    // Forward datapath and opposite-direction recompute for the self-check.
    always_comb begin
        s1_res_c   = apply_gate(s1_mode, s1_inv, s1_op);
        chk_back_c = apply_gate(s2_mode, ~s2_inv, s2_res);
        chk_bad_c  = chk_pend & (chk_back_c != s2_op);
    end

    // Stage 1 register: loads on accept, empties when it hands over to S2.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_mode  <= '0;
            s1_inv   <= 1'b0;
        end else if (accept_c) begin
            s1_valid <= 1'b1;
            s1_op    <= '{a: A, b: B, c: C};
            s1_mode  <= mode;
            s1_inv   <= inv;
        end else if (s2_load_c) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2 register: holds result steady while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_op    <= '0;
            s2_mode  <= '0;
            s2_inv   <= 1'b0;
        end else if (s2_load_c) begin
            s2_valid <= 1'b1;
            s2_res   <= s1_res_c;
            s2_op    <= s1_op;
            s2_mode  <= s1_mode;
            s2_inv   <= s1_inv;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // Self-check: compare the freshly loaded S2 contents one cycle after load.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_pend <= 1'b0;
            err      <= 1'b0;
        end else begin
            chk_pend <= s2_load_c;
            err      <= err | chk_bad_c;
        end
    end

    // Accepted-operation counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (accept_c && (op_count != {CNT_W{1'b1}})) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

    // Outputs come straight from the S2 registers.
    always_comb begin
        out_valid = s2_valid;
        P         = s2_res.a;
        Q         = s2_res.b;
        R         = s2_res.c;
    end

endmodule

// File: tb/tb_reversible_gate_unit.sv
// Directed and streaming bench for reversible_gate_unit, plus a CNT_W=4
// instance for counter saturation.
module tb_reversible_gate_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mode;
    logic        inv;
    logic [31:0] a, b, c;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p, q, r;
    logic [15:0] op_count;
    logic        err;

    logic        s_in_valid;
    logic        s_in_ready;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_p, s_q, s_r;
    logic [3:0]  s_op_count;
    logic        s_err;

    int checks = 0;
    int errors = 0;

    logic [95:0] sb[$];

    always #5 clk = ~clk;

    reversible_gate_unit #(.WIDTH(32), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .inv(inv),
        .A(a), .B(b), .C(c),
        .out_valid(out_valid), .out_ready(out_ready),
        .P(p), .Q(q), .R(r),
        .op_count(op_count), .err(err)
    );

    reversible_gate_unit #(.WIDTH(8), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .mode(2'd1), .inv(1'b0),
        .A(8'h0F), .B(8'h33), .C(8'h55),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .P(s_p), .Q(s_q), .R(s_r),
        .op_count(s_op_count), .err(s_err)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] model(input logic [1:0] m, input logic iv,
                                          input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z);
        case (m)
            2'd0:    model = {x, x ^ y, z};
            2'd1:    model = {x, y, (x & y) ^ z};
            2'd2:    model = {x, (~x & y) | (x & z), (~x & z) | (x & y)};
            default: model = iv ? {x, x ^ y, z ^ (x & (x ^ y))} : {x, x ^ y, (x & y) ^ z};
        endcase
    endfunction

    // Single transaction with out_ready=1: accept, wait bounded for result, check it.
    task automatic xfer(input string tag, input logic [1:0] m, input logic iv,
                        input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                        input logic [95:0] exp);
        int n;
        mode = m; inv = iv; a = x; b = y; c = z;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 8) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 8) begin tick(); n++; end
        chk({tag, "_valid"}, 96'(out_valid), 96'(1));
        chk(tag, {p, q, r}, exp);
        tick();
    endtask

    initial begin
        int sent, recv, cyc;
        logic [95:0] e;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        mode = '0; inv = 1'b0; a = '0; b = '0; c = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0;
        tick(); tick();
        chk("rst_out_valid", 96'(out_valid), 96'(0));
        chk("rst_pqr", {p, q, r}, 96'(0));
        chk("rst_op_count", 96'(op_count), 96'(0));
        chk("rst_err", 96'(err), 96'(0));
        chk("rst_in_ready", 96'(in_ready), 96'(0));
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 96'(in_ready), 96'(1));

        // Toffoli with explicit latency checks
        mode = 2'd1; inv = 1'b0; a = 32'h12345678; b = 32'h87654321; c = 32'h0;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("tof_lat1_valid", 96'(out_valid), 96'(0));
        chk("tof_op_count", 96'(op_count), 96'(1));
        tick();
        chk("tof_lat2_valid", 96'(out_valid), 96'(1));
        chk("tof_pqr", {p, q, r}, {32'h12345678, 32'h87654321, 32'h02244220});
        tick();
        chk("tof_drained", 96'(out_valid), 96'(0));

        xfer("fredkin", 2'd2, 1'b0, 32'hFFFF0000, 32'h12345678, 32'h87654321,
             {32'hFFFF0000, 32'h87655678, 32'h12344321});
        xfer("peres_fwd", 2'd3, 1'b0, 32'h12345678, 32'h87654321, 32'h00000000,
             {32'h12345678, 32'h95511559, 32'h02244220});
        xfer("peres_inv", 2'd3, 1'b1, 32'h12345678, 32'h95511559, 32'h02244220,
             {32'h12345678, 32'h87654321, 32'h00000000});
        tick();
        chk("directed_err", 96'(err), 96'(0));

        // Backpressure: three back-to-back inputs with out_ready low
        out_ready = 1'b0;
        mode = 2'd0; inv = 1'b0; a = 32'hA5A5A5A5; b = 32'h5A5A5A5A; c = 32'hFFFFFFFF;
        in_valid = 1'b1;
        #1;
        chk("bp_ready0", 96'(in_ready), 96'(1));
        tick();
        mode = 2'd1; inv = 1'b0; a = 32'hF0F0F0F0; b = 32'hFF00FF00; c = 32'h0000FFFF;
        #1;
        chk("bp_ready1", 96'(in_ready), 96'(1));
        tick();
        mode = 2'd0; inv = 1'b1; a = 32'h00000001; b = 32'h00000003; c = 32'hDEADBEEF;
        #1;
        chk("bp_full", 96'(in_ready), 96'(0));
        chk("bp_first", {p, q, r}, {32'hA5A5A5A5, 32'hFFFFFFFF, 32'hFFFFFFFF});
        tick();
        chk("bp_full_hold", 96'(in_ready), 96'(0));
        chk("bp_first_stable", {p, q, r}, {32'hA5A5A5A5, 32'hFFFFFFFF, 32'hFFFFFFFF});
        chk("bp_valid_stable", 96'(out_valid), 96'(1));
        out_ready = 1'b1;
        #1;
        chk("bp_ready_drain", 96'(in_ready), 96'(1));
        tick();
        in_valid = 1'b0;
        chk("bp_second", {p, q, r}, {32'hF0F0F0F0, 32'hFF00FF00, 32'hF0000FFF});
        tick();
        chk("bp_third", {p, q, r}, {32'h00000001, 32'h00000002, 32'hDEADBEEF});
        tick();
        chk("bp_empty", 96'(out_valid), 96'(0));
        chk("bp_op_count", 96'(op_count), 96'(7));

        // Reset with both stages full
        out_ready = 1'b0;
        mode = 2'd0; inv = 1'b0; a = 32'h11111111; b = 32'h22222222; c = 32'h33333333;
        in_valid = 1'b1;
        tick(); tick();
        chk("rm_full", 96'(in_ready), 96'(0));
        rst = 1'b1; in_valid = 1'b0;
        tick();
        chk("rm_out_valid", 96'(out_valid), 96'(0));
        chk("rm_pqr", {p, q, r}, 96'(0));
        chk("rm_op_count", 96'(op_count), 96'(0));
        chk("rm_in_ready", 96'(in_ready), 96'(0));
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("rm_rel_ready", 96'(in_ready), 96'(1));
        tick(); tick();
        chk("rm_no_ghost", 96'(out_valid), 96'(0));

        // Random streaming with random backpressure against the model
        sent = 0; recv = 0; cyc = 0;
        while ((sent < 1000 || sb.size() != 0) && cyc < 20000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 1000) begin
                in_valid = 1'($urandom_range(0, 1));
                mode = 2'($urandom_range(0, 3));
                inv  = 1'($urandom_range(0, 1));
                a = $urandom; b = $urandom; c = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("stream", {p, q, r}, e);
                end else begin
                    chk("stream_extra", 96'(1), 96'(0));
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(mode, inv, a, b, c));
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_sent", 96'(sent), 96'(1000));
        chk("stream_recv", 96'(recv), 96'(1000));
        chk("stream_err", 96'(err), 96'(0));

        // Saturation on the CNT_W=4 instance
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_mid", 96'(s_op_count), 96'(14));
        for (int i = 0; i < 6; i++) tick();
        s_in_valid = 1'b0;
        chk("sat_full", 96'(s_op_count), 96'(15));
        chk("sat_result", {72'(0), s_p, s_q, s_r}, {72'(0), 8'h0F, 8'h33, 8'h56});
        tick(); tick();
        chk("sat_hold", 96'(s_op_count), 96'(15));
        chk("sat_err", 96'(s_err), 96'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
